// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Brief    : Shared state encodings, constants and control bundle type for
//            the pipeline hazard sequencer.
// Revision : 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

    localparam logic [1:0] c_ST_RUN      = 2'd0;
    localparam logic [1:0] c_ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_ST_ERROR    = 2'd2;

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
    } hz_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : Hazard-unit bundle between the stage registers and the sequencer.
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_op_valid;
    logic             dmem_ack;
    logic             dmem_req;
    logic             pc_en;
    logic             if_id_en;
    logic             if_id_flush;
    logic             id_ex_en;
    logic             id_ex_flush;
    logic             ex_mem_en;
    logic             mem_wb_bubble;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_op_valid, dmem_ack,
        output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
               id_ex_flush, ex_mem_en, mem_wb_bubble, bus_err, stall_cycles
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
               ex_branch_taken, mem_op_valid, dmem_ack,
        input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en,
               id_ex_flush, ex_mem_en, mem_wb_bubble, bus_err, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_hazard_detect
// Brief    : Combinational branch / load-use priority resolution.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl_hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  wire logic [4:0] id_rs,
    input  wire logic [4:0] id_rt,
    input  wire logic       id_uses_rt,
    input  wire logic       ex_mem_read,
    input  wire logic [4:0] ex_rt,
    input  wire logic       ex_branch_taken,
    output hz_ctrl_t        ctrl
);
    logic w_load_use;

    // r0 is hardwired, so a load targeting it never creates a dependency
    assign w_load_use = ex_mem_read && (ex_rt != c_REG_ZERO) &&
                        ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    always_comb begin
        ctrl = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                 id_ex_en: 1'b1, id_ex_flush: 1'b0, ex_mem_en: 1'b1};
        if (ex_branch_taken) begin
            ctrl.if_id_flush = 1'b1;
            ctrl.id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            ctrl.pc_en       = 1'b0;
            ctrl.if_id_en    = 1'b0;
            ctrl.id_ex_flush = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush sequencer for the 5-stage pipeline with data-memory
//            wait handling, watchdog and stall counter.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  wire logic          clk,
    input  wire logic          rst,
    pipe_hazard_ctrl_if.master bus
);
    localparam int c_WAIT_W = $clog2(TIMEOUT) + 1;

    logic [1:0]          r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]    r_stall_cycles;
    logic                r_bus_err;

    hz_ctrl_t w_hz;
    hz_ctrl_t w_ctrl;
    logic     w_req;
    logic     w_bubble;

    pipe_hazard_ctrl_hazard_detect u_hazard_detect (
        .id_rs           (bus.id_rs),
        .id_rt           (bus.id_rt),
        .id_uses_rt      (bus.id_uses_rt),
        .ex_mem_read     (bus.ex_mem_read),
        .ex_rt           (bus.ex_rt),
        .ex_branch_taken (bus.ex_branch_taken),
        .ctrl            (w_hz)
    );

    // A pending memory access freezes the whole pipe; hazards resolve only
    // when the memory side is not holding it.
    always_comb begin
        w_ctrl   = '0;
        w_req    = 1'b0;
        w_bubble = 1'b0;
        if (!rst) begin
            case (r_state)
                c_ST_RUN: begin
                    w_req = bus.mem_op_valid;
                    if (bus.mem_op_valid && !bus.dmem_ack) w_bubble = 1'b1;
                    else                                   w_ctrl   = w_hz;
                end
                c_ST_MEM_WAIT: begin
                    w_req = 1'b1;
                    if (bus.dmem_ack) w_ctrl   = w_hz;
                    else              w_bubble = 1'b1;
                end
                default: w_bubble = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_RUN;
            r_wait_cnt     <= '0;
            r_stall_cycles <= '0;
            r_bus_err      <= 1'b0;
        end else begin
            if (!w_ctrl.pc_en && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            case (r_state)
                c_ST_RUN: begin
                    if (bus.mem_op_valid && !bus.dmem_ack) begin
                        r_state    <= c_ST_MEM_WAIT;
                        r_wait_cnt <= c_WAIT_W'(1);
                    end
                end
                c_ST_MEM_WAIT: begin
                    if (bus.dmem_ack) begin
                        r_state    <= c_ST_RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1)) begin
                        r_state   <= c_ST_ERROR;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                    end
                end
                default: begin
                    r_state   <= c_ST_ERROR;
                    r_bus_err <= 1'b1;
                end
            endcase
        end
    end

    assign bus.dmem_req      = w_req;
    assign bus.pc_en         = w_ctrl.pc_en;
    assign bus.if_id_en      = w_ctrl.if_id_en;
    assign bus.if_id_flush   = w_ctrl.if_id_flush;
    assign bus.id_ex_en      = w_ctrl.id_ex_en;
    assign bus.id_ex_flush   = w_ctrl.id_ex_flush;
    assign bus.ex_mem_en     = w_ctrl.ex_mem_en;
    assign bus.mem_wb_bubble = w_bubble;
    // Registered status is masked during reset so every output reads zero
    assign bus.bus_err       = r_bus_err & ~rst;
    assign bus.stall_cycles  = rst ? '0 : r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Scoreboard bench: directed hazard scenarios plus random traffic.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int c_SAT   = (1 << CNT_W) - 1;

    typedef struct {
        bit       rst;
        bit [4:0] id_rs;
        bit [4:0] id_rt;
        bit       uses_rt;
        bit       ex_mem_read;
        bit [4:0] ex_rt;
        bit       br;
        bit       mem_op;
        bit       ack;
    } stim_t;

    // ctl = {dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
    //        ex_mem_en, mem_wb_bubble, bus_err}
    typedef struct {
        bit [8:0] ctl;
        int       stall;
        int       cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    // Reference model: how many cycles the current access has been stalled,
    // whether the watchdog fired, and the number of frozen-PC cycles.
    int m_stalled = 0;
    bit m_err     = 0;
    int m_stall   = 0;

    function automatic bit [5:0] resolve(stim_t s);
        bit dep;
        dep = s.ex_mem_read && (s.ex_rt != 0) &&
              ((s.ex_rt == s.id_rs) || (s.uses_rt && (s.ex_rt == s.id_rt)));
        if (s.br) return 6'b111111;
        if (dep)  return 6'b000111;
        return 6'b110101;
    endfunction

    function automatic exp_t model(stim_t s);
        exp_t     e;
        bit       req = 0, bub = 0, er = 0;
        bit [5:0] h = '0;
        e.cyc = cyc;
        if (s.rst) begin
            m_stalled = 0; m_err = 0; m_stall = 0;
            e.ctl = '0; e.stall = 0;
            return e;
        end
        e.stall = m_stall;
        if (m_err) begin
            bub = 1; er = 1;
        end else if (m_stalled > 0) begin
            req = 1;
            if (s.ack) begin
                h = resolve(s); m_stalled = 0;
            end else begin
                bub = 1; m_stalled++;
                if (m_stalled == TIMEOUT) begin m_err = 1; m_stalled = 0; end
            end
        end else begin
            req = s.mem_op;
            if (s.mem_op && !s.ack) begin bub = 1; m_stalled = 1; end
            else h = resolve(s);
        end
        if (!h[5] && m_stall < c_SAT) m_stall++;
        e.ctl = {req, h, bub, er};
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '{rst: 0, id_rs: 5'd1, id_rt: 5'd2, uses_rt: 1, ex_mem_read: 0,
              ex_rt: 5'd3, br: 0, mem_op: 0, ack: 0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        @(posedge clk);
        #1;
        rst                 = s.rst;
        bus.id_rs           = s.id_rs;
        bus.id_rt           = s.id_rt;
        bus.id_uses_rt      = s.uses_rt;
        bus.ex_mem_read     = s.ex_mem_read;
        bus.ex_rt           = s.ex_rt;
        bus.ex_branch_taken = s.br;
        bus.mem_op_valid    = s.mem_op;
        bus.dmem_ack        = s.ack;
        cyc++;
        q.push_back(model(s));
    endtask

    // Monitor: every cycle the DUT presents a full control word
    initial begin
        exp_t     e;
        bit [8:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                got = {bus.dmem_req, bus.pc_en, bus.if_id_en, bus.if_id_flush,
                       bus.id_ex_en, bus.id_ex_flush, bus.ex_mem_en,
                       bus.mem_wb_bubble, bus.bus_err};
                n_checks++;
                if (got === e.ctl) n_pass++;
                else $display("FAIL ctl cycle %0d: got %b expected %b", e.cyc, got, e.ctl);
                n_checks++;
                if (32'(bus.stall_cycles) == e.stall) n_pass++;
                else $display("FAIL stall_cycles cycle %0d: got %0d expected %0d",
                              e.cyc, bus.stall_cycles, e.stall);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 0; bus.ex_mem_read = 0;
        bus.ex_rt = '0; bus.ex_branch_taken = 0; bus.mem_op_valid = 0; bus.dmem_ack = 0;

        s = idle(); s.rst = 1;
        repeat (2) drive(s);

        // load-use on rs, then recovery
        s = idle(); s.ex_mem_read = 1; s.ex_rt = 5'd5; s.id_rs = 5'd5;
        drive(s);
        repeat (2) drive(idle());
        // load to r0 is harmless
        s = idle(); s.ex_mem_read = 1; s.ex_rt = 5'd0; s.id_rs = 5'd0; s.id_rt = 5'd0;
        drive(s);
        // load-use through rt, and rt ignored when not a source
        s = idle(); s.ex_mem_read = 1; s.ex_rt = 5'd2;
        drive(s);
        s.uses_rt = 0;
        drive(s);
        // three-cycle memory wait released by ack
        s = idle(); s.mem_op = 1;
        repeat (3) drive(s);
        s.ack = 1;
        drive(s);
        drive(idle());
        // branch beats load-use
        s = idle(); s.br = 1; s.ex_mem_read = 1; s.ex_rt = 5'd7; s.id_rs = 5'd7;
        drive(s);
        // frozen branch seen again on release
        s = idle(); s.mem_op = 1; s.br = 1;
        drive(s);
        s.ack = 1;
        drive(s);
        // watchdog, sticky error, reset recovery
        s = idle(); s.mem_op = 1;
        repeat (6) drive(s);
        repeat (2) drive(idle());
        s = idle(); s.rst = 1;
        drive(s);
        drive(idle());
        // reset in the middle of a wait
        s = idle(); s.mem_op = 1;
        repeat (2) drive(s);
        s.rst = 1;
        drive(s);
        s.rst = 0; s.mem_op = 0;
        drive(s);

        for (int i = 0; i < 3000; i++) begin
            s.rst         = ($urandom_range(99) < 3);
            s.id_rs       = 5'($urandom_range(3));
            s.id_rt       = 5'($urandom_range(3));
            s.uses_rt     = 1'($urandom_range(1));
            s.ex_mem_read = 1'($urandom_range(1));
            s.ex_rt       = 5'($urandom_range(3));
            s.br          = ($urandom_range(99) < 20);
            s.mem_op      = ($urandom_range(99) < 30);
            s.ack         = ($urandom_range(99) < 40);
            drive(s);
        end

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
